axi_ss_bridge: RTL
==================

Name: axi_ss_bridge

Overview:
- Single-outstanding AXI4 slave that converts transactions from the zeroriscy_sim_top master port into the simple ss_req/ss_gnt/ss_rvalid peripheral bus used by uart_sim and other sim peripherals.
- Replaces the fixed-latency loopback wiring in the simulation harness with a real handshake, error and timeout path.

Parameters:
- ADDR_W, 32, address width on both sides.
- TIMEOUT, 256, cycles allowed from entering a backend request state to ss_rvalid; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- S_AXI_AWADDR/AWLEN/AWSIZE/AWVALID  in  ADDR_W/8/3/1  write address.
- S_AXI_AWREADY  out  1.
- S_AXI_WDATA/WSTRB/WLAST/WVALID  in  32/4/1/1  write data.
- S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2;  S_AXI_BVALID  out  1;  S_AXI_BREADY  in  1.
- S_AXI_ARADDR/ARLEN/ARSIZE/ARVALID  in  ADDR_W/8/3/1  read address.
- S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32;  S_AXI_RRESP  out  2;  S_AXI_RLAST  out  1;  S_AXI_RVALID  out  1;  S_AXI_RREADY  in  1.
- ss_req  out  1;  ss_we  out  1;  ss_be  out  4;  ss_addr  out  ADDR_W;  ss_wdata  out  32.
- ss_gnt  in  1;  ss_rvalid  in  1;  ss_rdata  in  32;  ss_err  in  1.

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE.
  - Priority flag is set to WRITE.
  - Reset mid-transaction aborts it. No B or R beat is issued for the aborted transaction. An ss_rvalid arriving after reset is ignored.
- States: IDLE, WR_CAP, WR_DRAIN, WR_REQ, WR_WAIT, WR_RESP, RD_CAP, RD_REQ, RD_WAIT, RD_RESP.
- IDLE arbitration:
  - AWVALID alone goes to WR_CAP; ARVALID alone goes to RD_CAP.
  - If both are valid, the priority flag decides.
  - The flag toggles to the other direction after each completed transaction (round-robin).
  - All READYs are 0 in IDLE.
- WR_CAP:
  - AWREADY = !aw_got and WREADY = !w_got. These are combinational from flags, and AW and W may arrive in either order or in the same cycle.
  - AW and W data are captured on handshake.
  - When both are captured:
    - If AWLEN == 0 and AWSIZE <= 2, go to WR_REQ.
    - Otherwise, if WLAST was 0, go to WR_DRAIN; if it was 1, go to WR_RESP with SLVERR.
  - WLAST is ignored when AWLEN == 0.
- WR_DRAIN: WREADY = 1; W beats are discarded. On a handshake with WLAST = 1, go to WR_RESP with BRESP = SLVERR (2'b10).
- WR_REQ:
  - Drives ss_req = 1, ss_we = 1, ss_be = WSTRB, ss_addr = AWADDR, ss_wdata = WDATA.
  - These are held stable until ss_gnt; on ss_gnt go to WR_WAIT and ss_req drops the next cycle.
  - Minimum latency is one ss_req cycle.
- WR_WAIT: on ss_rvalid, BRESP = ss_err ? SLVERR : OKAY; go to WR_RESP.
- WR_RESP: BVALID = 1, held with BRESP stable until BREADY; then go to IDLE.
- RD_CAP:
  - ARREADY = 1 for exactly one cycle; ARADDR/LEN/SIZE are captured and beats = ARLEN + 1.
  - If ARLEN == 0 and ARSIZE <= 2, go to RD_REQ.
  - Otherwise go to RD_RESP with RRESP = SLVERR and RDATA = 0 for every beat.
- RD_REQ: ss_req = 1, ss_we = 0, ss_be = 4'hF, ss_addr = ARADDR; on ss_gnt go to RD_WAIT.
- RD_WAIT: on ss_rvalid, RDATA = ss_rdata and RRESP = ss_err ? SLVERR : OKAY; go to RD_RESP.
- RD_RESP:
  - RVALID = 1; RLAST = 1 when beats == 1.
  - On RREADY, decrement beats; at 0 go to IDLE, otherwise present the next beat the following cycle.
  - RVALID may stay high back-to-back across beats.
- Timeout:
  - The counter clears on entry to WR_REQ or RD_REQ and counts every cycle in the REQ and WAIT states.
  - When it reaches TIMEOUT: ss_req deasserts and the block goes to the RESP state with SLVERR (RDATA = 0).
  - Any later ss_rvalid for the abandoned access is ignored.
- The bridge never accepts a new AW or AR until the current B or final R handshake completes.
- ss_rvalid in the same cycle as ss_gnt is legal and accepted; the block goes straight to RESP, skipping WAIT.

Test Plan:
- Write 0x9a100008, data 0x41, WSTRB 0001, gnt same cycle, rvalid next cycle -> ss_we = 1, ss_be = 0001, ss_wdata = 0x41; BVALID with BRESP = 00 within 4 cycles.
- W presented 3 cycles before AW -> WREADY handshakes first; single ss_req with the correct address; BRESP = 00.
- Read 0x9a100004 with ss_rdata = 0x0000_0060 and RREADY held low 5 cycles -> RVALID, RDATA, RRESP = 00 and RLAST = 1 stay stable until RREADY.
- AWVALID and ARVALID asserted together repeatedly -> order is write, read, write, read; exactly one ss_req active at a time.
- ARLEN = 3 -> no ss_req; 4 R beats of SLVERR with RDATA = 0 and RLAST only on beat 4. AWLEN = 1 with 2 W beats -> both drained; BRESP = 10.
- TIMEOUT = 8, peripheral never asserts gnt -> ss_req drops after 8 cycles; BRESP = 10; late ss_rvalid ignored. Reset asserted in RD_WAIT -> all outputs 0 the next cycle and no R beat.

Source files
------------

// File: rtl/axi_ss_bridge_if.sv
// AXI4 slave port plus ss_req/ss_gnt peripheral bus seen by axi_ss_bridge.
// slave = bridge view, master = AXI master and peripheral side.
interface axi_ss_bridge_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic [7:0]        S_AXI_AWLEN;
    logic [2:0]        S_AXI_AWSIZE;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [31:0]       S_AXI_WDATA;
    logic [3:0]        S_AXI_WSTRB;
    logic              S_AXI_WLAST;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic [7:0]        S_AXI_ARLEN;
    logic [2:0]        S_AXI_ARSIZE;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [31:0]       S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RLAST;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;
    logic              ss_req;
    logic              ss_we;
    logic [3:0]        ss_be;
    logic [ADDR_W-1:0] ss_addr;
    logic [31:0]       ss_wdata;
    logic              ss_gnt;
    logic              ss_rvalid;
    logic [31:0]       ss_rdata;
    logic              ss_err;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY,
        output ss_req, ss_we, ss_be, ss_addr, ss_wdata,
        input  ss_gnt, ss_rvalid, ss_rdata, ss_err
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY,
        input  ss_req, ss_we, ss_be, ss_addr, ss_wdata,
        output ss_gnt, ss_rvalid, ss_rdata, ss_err
    );
endinterface

// File: rtl/axi_ss_bridge.sv
// Single-outstanding AXI4 slave to ss_req/ss_gnt/ss_rvalid bridge with timeout.
// Latency: >=1 ss_req cycle after capture; BREADY/RREADY stall the response state.
module axi_ss_bridge #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    axi_ss_bridge_if.slave       bus
);
    typedef enum logic [3:0] {
        IDLE, WR_CAP, WR_DRAIN, WR_REQ, WR_WAIT, WR_RESP,
        RD_CAP, RD_REQ, RD_WAIT, RD_RESP
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    state_t            state;
    logic              aw_got, w_got, prio_wr, stale;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [31:0]       wdata_q, rdata_q, cnt;
    logic [3:0]        strb_q;
    logic              wlast_q;
    logic [1:0]        resp_q;
    logic [8:0]        beats;

    logic       aw_hs, w_hs, aw_now, w_now, wr_ok, wlast_n, tmo_hit, rsp_vld;
    logic [7:0] len_n;
    logic [2:0] size_n;
    logic [1:0] ss_resp;

    // Either AW or W may be the one completing the capture, so merge live and stored fields.
    assign aw_hs   = (state == WR_CAP) && !aw_got && bus.S_AXI_AWVALID;
    assign w_hs    = (state == WR_CAP) && !w_got && bus.S_AXI_WVALID;
    assign aw_now  = aw_got | aw_hs;
    assign w_now   = w_got | w_hs;
    assign len_n   = aw_got ? len_q : bus.S_AXI_AWLEN;
    assign size_n  = aw_got ? size_q : bus.S_AXI_AWSIZE;
    assign wlast_n = w_got ? wlast_q : bus.S_AXI_WLAST;
    assign wr_ok   = (len_n == 8'd0) && (size_n <= 3'd2);
    assign tmo_hit = (TIMEOUT != 0) && (cnt >= 32'(TIMEOUT - 1));
    assign rsp_vld = bus.ss_rvalid && !stale;
    assign ss_resp = bus.ss_err ? SLVERR : OKAY;

    assign bus.S_AXI_AWREADY = (state == WR_CAP) && !aw_got;
    assign bus.S_AXI_WREADY  = ((state == WR_CAP) && !w_got) || (state == WR_DRAIN);
    assign bus.S_AXI_ARREADY = (state == RD_CAP);
    assign bus.S_AXI_BVALID  = (state == WR_RESP);
    assign bus.S_AXI_BRESP   = (state == WR_RESP) ? resp_q : OKAY;
    assign bus.S_AXI_RVALID  = (state == RD_RESP);
    assign bus.S_AXI_RRESP   = (state == RD_RESP) ? resp_q : OKAY;
    assign bus.S_AXI_RDATA   = (state == RD_RESP) ? rdata_q : 32'd0;
    assign bus.S_AXI_RLAST   = (state == RD_RESP) && (beats == 9'd1);
    assign bus.ss_req        = (state == WR_REQ) || (state == RD_REQ);
    assign bus.ss_we         = (state == WR_REQ);
    assign bus.ss_be         = (state == WR_REQ) ? strb_q : ((state == RD_REQ) ? 4'hF : 4'h0);
    assign bus.ss_addr       = bus.ss_req ? addr_q : '0;
    assign bus.ss_wdata      = (state == WR_REQ) ? wdata_q : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            prio_wr <= 1'b1;
            stale   <= 1'b0;
            addr_q  <= '0;
            len_q   <= 8'd0;
            size_q  <= 3'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            strb_q  <= 4'd0;
            wlast_q <= 1'b0;
            resp_q  <= OKAY;
            beats   <= 9'd0;
            cnt     <= 32'd0;
        end else begin
            // A response owed to an abandoned access is swallowed exactly once.
            if (bus.ss_rvalid) stale <= 1'b0;
            case (state)
                IDLE: begin
                    aw_got <= 1'b0;
                    w_got  <= 1'b0;
                    resp_q <= OKAY;
                    if (bus.S_AXI_AWVALID && (!bus.S_AXI_ARVALID || prio_wr)) state <= WR_CAP;
                    else if (bus.S_AXI_ARVALID) state <= RD_CAP;
                end
                WR_CAP: begin
                    if (aw_hs) begin
                        aw_got <= 1'b1;
                        addr_q <= bus.S_AXI_AWADDR;
                        len_q  <= bus.S_AXI_AWLEN;
                        size_q <= bus.S_AXI_AWSIZE;
                    end
                    if (w_hs) begin
                        w_got   <= 1'b1;
                        wdata_q <= bus.S_AXI_WDATA;
                        strb_q  <= bus.S_AXI_WSTRB;
                        wlast_q <= bus.S_AXI_WLAST;
                    end
                    if (aw_now && w_now) begin
                        if (wr_ok) begin
                            state <= WR_REQ;
                            cnt   <= 32'd0;
                        end else if (wlast_n || (len_n == 8'd0)) begin
                            state  <= WR_RESP;
                            resp_q <= SLVERR;
                        end else begin
                            state <= WR_DRAIN;
                        end
                    end
                end
                WR_DRAIN: begin
                    if (bus.S_AXI_WVALID && bus.S_AXI_WLAST) begin
                        state  <= WR_RESP;
                        resp_q <= SLVERR;
                    end
                end
                WR_REQ: begin
                    cnt <= cnt + 32'd1;
                    if (bus.ss_gnt && rsp_vld) begin
                        state  <= WR_RESP;
                        resp_q <= ss_resp;
                    end else if (bus.ss_gnt) begin
                        state <= WR_WAIT;
                    end else if (tmo_hit) begin
                        state  <= WR_RESP;
                        resp_q <= SLVERR;
                    end
                end
                WR_WAIT: begin
                    cnt <= cnt + 32'd1;
                    if (rsp_vld) begin
                        state  <= WR_RESP;
                        resp_q <= ss_resp;
                    end else if (tmo_hit) begin
                        state  <= WR_RESP;
                        resp_q <= SLVERR;
                        stale  <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (bus.S_AXI_BREADY) begin
                        state   <= IDLE;
                        prio_wr <= 1'b0;
                    end
                end
                RD_CAP: begin
                    if (bus.S_AXI_ARVALID) begin
                        addr_q <= bus.S_AXI_ARADDR;
                        beats  <= {1'b0, bus.S_AXI_ARLEN} + 9'd1;
                        if ((bus.S_AXI_ARLEN == 8'd0) && (bus.S_AXI_ARSIZE <= 3'd2)) begin
                            state <= RD_REQ;
                            cnt   <= 32'd0;
                        end else begin
                            state   <= RD_RESP;
                            resp_q  <= SLVERR;
                            rdata_q <= 32'd0;
                        end
                    end
                end
                RD_REQ: begin
                    cnt <= cnt + 32'd1;
                    if (bus.ss_gnt && rsp_vld) begin
                        state   <= RD_RESP;
                        resp_q  <= ss_resp;
                        rdata_q <= bus.ss_rdata;
                    end else if (bus.ss_gnt) begin
                        state <= RD_WAIT;
                    end else if (tmo_hit) begin
                        state   <= RD_RESP;
                        resp_q  <= SLVERR;
                        rdata_q <= 32'd0;
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt + 32'd1;
                    if (rsp_vld) begin
                        state   <= RD_RESP;
                        resp_q  <= ss_resp;
                        rdata_q <= bus.ss_rdata;
                    end else if (tmo_hit) begin
                        state   <= RD_RESP;
                        resp_q  <= SLVERR;
                        rdata_q <= 32'd0;
                        stale   <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (bus.S_AXI_RREADY) begin
                        beats <= beats - 9'd1;
                        if (beats == 9'd1) begin
                            state   <= IDLE;
                            prio_wr <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
